// File: rtl/vga_timing_ctrl_pkg.sv
// Shared raster constants for the 640x480@60 Hz display path.
// Both the timing controller and the pixel generator take these values
// so that they agree on geometry and colour encoding.
package vga_timing_ctrl_pkg;

   // Horizontal timing, in pixel clocks
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BACK  = 48;
   localparam int DEF_H_VALID = 640;
   localparam int DEF_H_FRONT = 16;

   // Vertical timing, in lines
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BACK  = 33;
   localparam int DEF_V_VALID = 480;
   localparam int DEF_V_FRONT = 10;

   // Derived totals and visible-window starts
   localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_VALID + DEF_H_FRONT;
   localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_VALID + DEF_V_FRONT;
   localparam int DEF_HS      = DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_VS      = DEF_V_SYNC + DEF_V_BACK;

   // Counter/coordinate width and the "no coordinate" marker
   localparam int              CNT_W      = 10;
   localparam logic [CNT_W-1:0] COORD_NONE = 10'h3FF;

   // RGB565 colour constants
   localparam logic [15:0] BLACK = 16'h0000;
   localparam logic [15:0] WHITE = 16'hFFFF;

endpackage

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator: horizontal/vertical counters, sync decode,
// visible-window flag, pixel-request coordinates (leading the visible
// window by PIX_LAT cycles) and gating of returned pixel data onto rgb.
module vga_timing_ctrl
   import vga_timing_ctrl_pkg::*;
#(
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BACK   = DEF_H_BACK,
   parameter int   H_VALID  = DEF_H_VALID,
   parameter int   H_FRONT  = DEF_H_FRONT,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BACK   = DEF_V_BACK,
   parameter int   V_VALID  = DEF_V_VALID,
   parameter int   V_FRONT  = DEF_V_FRONT,
   parameter logic SYNC_POL = 1'b1,
   parameter int   PIX_LAT  = 1
) (
   input  logic             vga_clk,
   input  logic             sys_rst,
   input  logic [15:0]      pix_data,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             hsync,
   output logic             vsync,
   output logic             rgb_valid,
   output logic [15:0]      rgb,
   output logic             frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HS      = H_SYNC + H_BACK;
   localparam int VS      = V_SYNC + V_BACK;

   // All compare points sized to the counter width; every value fits in
   // 10 bits because both totals are at most 1024.
   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HSYNC_END   = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] VSYNC_END   = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] VIS_H_START = CNT_W'(HS);
   localparam logic [CNT_W-1:0] VIS_H_END   = CNT_W'(HS + H_VALID);
   localparam logic [CNT_W-1:0] VIS_V_START = CNT_W'(VS);
   localparam logic [CNT_W-1:0] VIS_V_END   = CNT_W'(VS + V_VALID);
   // The request window is the visible window pulled earlier by PIX_LAT.
   // PIX_LAT never exceeds the back porch, so it stays inside one line.
   localparam logic [CNT_W-1:0] REQ_H_START = CNT_W'(HS - PIX_LAT);
   localparam logic [CNT_W-1:0] REQ_H_END   = CNT_W'(HS + H_VALID - PIX_LAT);

   logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
   logic [CNT_W-1:0] cnt_v_q, cnt_v_d;
   logic             lineEnd;
   logic             rowActive;
   logic             colVisible;
   logic             colRequest;
   logic             inRequest;

   // Next-state for both counters: the horizontal counter free-runs and
   // wraps at the end of the line, the vertical one steps only then.
   always_comb begin
      cnt_h_d = cnt_h_q + CNT_W'(1);
      cnt_v_d = cnt_v_q;
      lineEnd = (cnt_h_q == H_LAST);
      if (lineEnd) begin
         cnt_h_d = '0;
         if (cnt_v_q == V_LAST) begin
            cnt_v_d = '0;
         end else begin
            cnt_v_d = cnt_v_q + CNT_W'(1);
         end
      end
   end

   // Horizontal counter register; reset restarts the frame from any point.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         cnt_h_q <= '0;
      end else begin
         cnt_h_q <= cnt_h_d;
      end
   end

   // Vertical counter register; reset alongside the horizontal counter.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         cnt_v_q <= '0;
      end else begin
         cnt_v_q <= cnt_v_d;
      end
   end

   // Window decodes taken straight from the registered counters so the
   // syncs and flags cannot glitch on counter carries.
   assign rowActive  = (cnt_v_q >= VIS_V_START) && (cnt_v_q < VIS_V_END);
   assign colVisible = (cnt_h_q >= VIS_H_START) && (cnt_h_q < VIS_H_END);
   assign colRequest = (cnt_h_q >= REQ_H_START) && (cnt_h_q < REQ_H_END);
   assign inRequest  = rowActive && colRequest;

   assign hsync       = (cnt_h_q < HSYNC_END) ? SYNC_POL : ~SYNC_POL;
   assign vsync       = (cnt_v_q < VSYNC_END) ? SYNC_POL : ~SYNC_POL;
   assign rgb_valid   = rowActive && colVisible;
   assign frame_start = (cnt_h_q == '0) && (cnt_v_q == '0);

   // Coordinates only mean anything inside the request window, which is
   // also what keeps these subtractions from ever underflowing.
   assign pix_x = inRequest ? (cnt_h_q - REQ_H_START) : COORD_NONE;
   assign pix_y = inRequest ? (cnt_v_q - VIS_V_START) : COORD_NONE;

   assign rgb = rgb_valid ? pix_data : BLACK;

endmodule
